// File: rtl/rle_word_packer.sv
// ============================================================================
// Module   : rle_word_packer
// Brief    : Expands (symbol, count) runs and packs the symbols into N-bit words.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rle_word_packer #(
    parameter int N    = 32,
    parameter int SYMW = 1,
    parameter int CW   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SYMW-1:0]             in_sym,
    input  logic [CW-1:0]               in_count,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0]                out_data,
    output logic [$clog2(N/SYMW):0]     out_fill,
    output logic                        out_last
);

    localparam int S  = N / SYMW;
    localparam int PW = $clog2(S) + 1;
    localparam int AW = ((CW + 1) > PW) ? (CW + 1) : PW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SYMW-1:0]   sym_q, sym_d;
    logic [CW:0]       rem_q, rem_d;
    logic              last_q, last_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [N-1:0]      asm_q, asm_d;
    logic              out_valid_q, out_valid_d;
    logic [N-1:0]      out_data_q, out_data_d;
    logic [PW-1:0]     out_fill_q, out_fill_d;
    logic              out_last_q, out_last_d;

    logic              slot_free;
    logic [AW-1:0]     rem_ext, space, k, end_pos;
    logic [CW:0]       new_rem;
    logic [N-1:0]      placed;
    logic              word_done;

    // Placement of up to one word's worth of the current run per edge.
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        rem_ext   = AW'(rem_q);
        space     = AW'(S) - AW'(pos_q);
        k         = (rem_ext < space) ? rem_ext : space;
        end_pos   = AW'(pos_q) + k;
        new_rem   = rem_q - k[CW:0];
        placed    = asm_q;
        for (int i = 0; i < S; i++) begin
            if ((AW'(i) >= AW'(pos_q)) && (AW'(i) < end_pos)) begin
                placed[i*SYMW +: SYMW] = sym_q;
            end
        end
        word_done = (end_pos == AW'(S)) || ((new_rem == '0) && last_q);
    end

    always_comb begin
        state_d     = state_q;
        sym_d       = sym_q;
        rem_d       = rem_q;
        last_d      = last_q;
        pos_d       = pos_q;
        asm_d       = asm_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_fill_d  = out_fill_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sym_d   = in_sym;
                    rem_d   = {1'b0, in_count};
                    last_d  = in_last;
                    state_d = FILL;
                end
            end
            FILL: begin
                rem_d = new_rem;
                if (word_done && slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = placed;
                    out_fill_d  = end_pos[PW-1:0];
                    out_last_d  = last_q && (new_rem == '0);
                    asm_d       = '0;
                    pos_d       = '0;
                    state_d     = (new_rem != '0) ? FILL : IDLE;
                end else begin
                    asm_d   = placed;
                    pos_d   = end_pos[PW-1:0];
                    if (word_done) begin
                        state_d = EMIT;
                    end else begin
                        state_d = (new_rem != '0) ? FILL : IDLE;
                    end
                end
            end
            EMIT: begin
                // Held word sits in the assembly register with pos as its fill.
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = asm_q;
                    out_fill_d  = pos_q;
                    out_last_d  = last_q && (rem_q == '0);
                    asm_d       = '0;
                    pos_d       = '0;
                    state_d     = (rem_q != '0) ? FILL : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sym_q       <= '0;
            rem_q       <= '0;
            last_q      <= 1'b0;
            pos_q       <= '0;
            asm_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_fill_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_q       <= sym_d;
            rem_q       <= rem_d;
            last_q      <= last_d;
            pos_q       <= pos_d;
            asm_q       <= asm_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_fill_q  <= out_fill_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_fill  = out_fill_q;
    assign out_last  = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_rle_word_packer.sv
// ============================================================================
// Module   : tb_rle_word_packer
// Brief    : Directed and random checks of rle_word_packer (SYMW=1 and SYMW=4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rle_word_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // unit 0: N=32, SYMW=1
    logic        iv0, ir0, il0, ov0, or0, ol0;
    logic [0:0]  is0;
    logic [7:0]  ic0;
    logic [31:0] od0;
    logic [5:0]  of0;
    // unit 1: N=32, SYMW=4
    logic        iv1, ir1, il1, ov1, or1, ol1;
    logic [3:0]  is1;
    logic [7:0]  ic1;
    logic [31:0] od1;
    logic [3:0]  of1;

    rle_word_packer #(.N(32), .SYMW(1), .CW(8)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_sym(is0),
        .in_count(ic0), .in_last(il0), .out_valid(ov0), .out_ready(or0),
        .out_data(od0), .out_fill(of0), .out_last(ol0)
    );

    rle_word_packer #(.N(32), .SYMW(4), .CW(8)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_sym(is1),
        .in_count(ic1), .in_last(il1), .out_valid(ov1), .out_ready(or1),
        .out_data(od1), .out_fill(of1), .out_last(ol1)
    );

    typedef struct {
        logic [31:0] d;
        int          f;
        bit          l;
    } word_t;

    word_t       q0[$];
    word_t       q1[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mbuf[2];
    int          mpos[2];
    bit          rand_rdy = 1'b0;
    bit          manual_rdy = 1'b0;
    bit          acc0, acc1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int u, input logic [31:0] d, input int f, input bit l);
        word_t w;
        w.d = d;
        w.f = f;
        w.l = l;
        if (u == 0) q0.push_back(w);
        else        q1.push_back(w);
    endtask

    // Reference: symbols stream into a buffer; every S symbols make a word,
    // and a last run flushes whatever is left (even nothing, for count 0).
    task automatic model_run(input int u, input logic [3:0] sym, input int cnt, input bit last);
        int sw;
        int s;
        sw = (u == 0) ? 1 : 4;
        s  = 32 / sw;
        for (int c = 0; c < cnt; c++) begin
            for (int b = 0; b < sw; b++) mbuf[u][mpos[u]*sw + b] = sym[b];
            mpos[u]++;
            if (mpos[u] == s) begin
                push(u, mbuf[u], s, last && (c == cnt - 1));
                mbuf[u] = '0;
                mpos[u] = 0;
            end
        end
        if (last && (cnt == 0 || mpos[u] > 0)) begin
            push(u, mbuf[u], mpos[u], 1'b1);
            mbuf[u] = '0;
            mpos[u] = 0;
        end
    endtask

    task automatic mon(input int u, input logic v, input logic r, input logic [31:0] d,
                       input int f, input logic l);
        word_t w;
        int    sz;
        if (v !== 1'b1) return;
        sz = (u == 0) ? q0.size() : q1.size();
        checks++;
        assert (sz > 0) else begin
            errors++;
            $error("FAIL unexpected_word_u%0d observed=%0h expected=none", u, d);
        end
        if (sz > 0) begin
            w = (u == 0) ? q0[0] : q1[0];
            chk($sformatf("u%0d_data", u), 64'(d), 64'(w.d));
            chk($sformatf("u%0d_fill", u), 64'(f), 64'(w.f));
            chk($sformatf("u%0d_last", u), 64'(l), 64'(w.l));
            if (r === 1'b1) begin
                if (u == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        acc0 = iv0 && ir0;
        acc1 = iv1 && ir1;
        mon(0, ov0, or0, od0, int'(of0), ol0);
        mon(1, ov1, or1, od1, int'(of1), ol1);
        @(posedge clk);
        #1;
        if (!manual_rdy) begin
            or0 = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            or1 = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic drive(input int u, input logic [3:0] sym, input int cnt, input bit last,
                         input bit use_model);
        bit done;
        done = 1'b0;
        if (u == 0) begin
            is0 = sym[0:0]; ic0 = cnt[7:0]; il0 = last; iv0 = 1'b1;
        end else begin
            is1 = sym; ic1 = cnt[7:0]; il1 = last; iv1 = 1'b1;
        end
        for (int t = 0; t < 200; t++) begin
            tick();
            if ((u == 0 && acc0) || (u == 1 && acc1)) begin
                done = 1'b1;
                break;
            end
        end
        iv0 = 1'b0;
        iv1 = 1'b0;
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL accept_timeout_u%0d observed=no_accept expected=accept", u);
        end
        if (done && use_model) model_run(u, sym, cnt, last);
    endtask

    task automatic drain();
        for (int t = 0; t < 1000; t++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            tick();
        end
        checks++;
        assert (q0.size() == 0 && q1.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout observed=%0d/%0d expected=0/0", q0.size(), q1.size());
        end
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        iv0 = 1'b0; is0 = '0; ic0 = '0; il0 = 1'b0; or0 = 1'b1;
        iv1 = 1'b0; is1 = '0; ic1 = '0; il1 = 1'b0; or1 = 1'b1;
        mbuf[0] = '0; mbuf[1] = '0; mpos[0] = 0; mpos[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid0", 64'(ov0), 64'd0);
        chk("rst_data0",  64'(od0), 64'd0);
        chk("rst_fill0",  64'(of0), 64'd0);
        chk("rst_last0",  64'(ol0), 64'd0);
        chk("rst_ready0", 64'(ir0), 64'd1);
        chk("rst_valid1", 64'(ov1), 64'd0);
        chk("rst_data1",  64'(od1), 64'd0);
        chk("rst_ready1", 64'(ir1), 64'd1);
        reset = 1'b0;

        // two runs filling exactly one word
        push(0, 32'h0000_03FF, 32, 1'b0);
        drive(0, 4'h1, 10, 1'b0, 1'b0);
        drive(0, 4'h0, 22, 1'b0, 1'b0);
        drain();

        // long last run: back-to-back full words, first one edge after accept
        push(0, 32'hFFFF_FFFF, 32, 1'b0);
        push(0, 32'hFFFF_FFFF, 32, 1'b0);
        push(0, 32'h0000_003F, 6, 1'b1);
        drive(0, 4'h1, 70, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("b2b_valid%0d", i), 64'(ov0), 64'd1);
        end
        drain();

        // consumer stall after the first word
        push(0, 32'h0, 32, 1'b0);
        push(0, 32'h0, 32, 1'b0);
        push(0, 32'h0, 32, 1'b0);
        manual_rdy = 1'b1;
        or0 = 1'b1;
        drive(0, 4'h0, 96, 1'b0, 1'b0);
        tick();
        tick();
        or0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_valid%0d", i), 64'(ov0), 64'd1);
        end
        or0 = 1'b1;
        manual_rdy = 1'b0;
        drain();

        // reset in the middle of a run
        drive(0, 4'h0, 12, 1'b0, 1'b0);
        drive(0, 4'h1, 40, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        chk("midrst_valid", 64'(ov0), 64'd0);
        chk("midrst_data",  64'(od0), 64'd0);
        chk("midrst_fill",  64'(of0), 64'd0);
        chk("midrst_last",  64'(ol0), 64'd0);
        chk("midrst_ready", 64'(ir0), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(0, 32'hFFFF_FFFF, 32, 1'b0);
        drive(0, 4'h1, 32, 1'b0, 1'b0);
        drain();

        // empty flush
        push(0, 32'h0, 0, 1'b1);
        drive(0, 4'h0, 0, 1'b1, 1'b0);
        drain();

        // 4-bit symbols
        push(1, 32'h5555_5AAA, 8, 1'b0);
        drive(1, 4'hA, 3, 1'b0, 1'b0);
        drive(1, 4'h5, 5, 1'b0, 1'b0);
        drain();

        // random runs against the reference, random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int          u;
            logic [3:0]  sym;
            int          cnt;
            bit          last;
            u    = $urandom_range(0, 1);
            sym  = 4'($urandom);
            cnt  = $urandom_range(0, 80);
            last = ($urandom_range(0, 3) == 0);
            drive(u, sym, cnt, last, 1'b1);
        end
        drive(0, 4'h0, 0, 1'b1, 1'b1);
        drive(1, 4'h0, 0, 1'b1, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
